rvc_regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file; successor to the single-port srf in rvc_processor.

---
 rtl/rvc_pkg.sv | 20 ++
 rtl/rvc_rf_rdport.sv | 62 ++++++
 rtl/rvc_regfile_mp.sv | 119 +++++++++++
 tb/tb_rvc_regfile_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_pkg
//  Description : Shared constants and types for the rvc register file.
//  Revision    : 1.0  initial release
// ============================================================================
package rvc_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int ZERO_REG     = 0;

    // Clear-engine state encoding
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/rvc_rf_rdport.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_rf_rdport
//  Description : One registered read port. Masks x0 and out-of-range indices
//                to zero. With RVC_RF_BYPASS_EN defined, a same-cycle accepted
//                write to the read index is forwarded (write-first); otherwise
//                the read returns the stored content (read-before-write).
//  Revision    : 1.0  initial release
// ============================================================================
module rvc_rf_rdport
    import rvc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            wr_accept,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);

    logic            w_in_range;
    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_next;

    // Range check is only needed when NREG does not fill the address space
    generate
        if (NREG == (1 << AW)) begin : g_full_range
            assign w_in_range = 1'b1;
        end else begin : g_part_range
            assign w_in_range = (int'(rd_addr) < NREG);
        end
    endgenerate

`ifdef RVC_RF_BYPASS_EN
    // Forward the write data when the same index is committed this cycle
    assign w_src = (wr_accept && (wr_addr == rd_addr)) ? wr_data : reg_data;
`else
    // Read-before-write: stored content only; write-side inputs are not needed
    assign w_src = reg_data;
    logic w_unused_bypass;
    assign w_unused_bypass = ^{wr_accept, wr_addr, wr_data};
`endif

    assign w_next = ((rd_addr == AW'(ZERO_REG)) || !w_in_range) ? '0 : w_src;

    // Register the selected operand
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvc_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_regfile_mp
//  Description : Multi-read-port integer register file with hardwired x0,
//                registered reads, write-done pulse and a bulk-clear engine
//                (busy/clr_done). Optional macro: RVC_RF_BYPASS_EN enables
//                write-first forwarding on the read ports.
//  Revision    : 1.0  initial release
// ============================================================================
module rvc_regfile_mp
    import rvc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG),
    parameter int NRP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    output logic                wr_done,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done
);

    rf_state_t       r_state;
    logic [AW-1:0]   r_clr_cnt;
    logic            r_wr_done;
    logic            r_clr_done;
    logic [XLEN-1:0] r_regs [NREG];

    logic            w_wr_in_range;
    logic            w_wr_accept;

    // Write index range check, trivially true for power-of-two NREG
    generate
        if (NREG == (1 << AW)) begin : g_wr_full_range
            assign w_wr_in_range = 1'b1;
        end else begin : g_wr_part_range
            assign w_wr_in_range = (int'(wr_addr) < NREG);
        end
    endgenerate

    // A clear request in the same cycle takes priority over the write
    assign w_wr_accept = !rst && (r_state == RF_IDLE) && wr_en && !clr_req &&
                         (wr_addr != AW'(ZERO_REG)) && w_wr_in_range;

    // Clear FSM, clear index and handshake pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RF_CLEAR;
            r_clr_cnt  <= AW'(1);
            r_wr_done  <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_wr_done  <= w_wr_accept;
            r_clr_done <= 1'b0;
            case (r_state)
                RF_IDLE: begin
                    if (clr_req) begin
                        r_state   <= RF_CLEAR;
                        r_clr_cnt <= AW'(1);
                    end
                end
                RF_CLEAR: begin
                    if (r_clr_cnt == AW'(NREG - 1)) begin
                        r_state    <= RF_IDLE;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + AW'(1);
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                end
            endcase
        end
    end

    // Storage: clear engine zeroes one register per cycle, otherwise writeback
    always_ff @(posedge clk) begin
        if (r_state == RF_CLEAR) begin
            r_regs[r_clr_cnt] <= '0;
        end else if (w_wr_accept) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Independent read ports
    generate
        for (genvar p = 0; p < NRP; p++) begin : g_rdport
            rvc_rf_rdport #(
                .XLEN (XLEN),
                .NREG (NREG),
                .AW   (AW)
            ) u_rdport (
                .clk       (clk),
                .rst       (rst),
                .rd_addr   (rd_addr[p*AW +: AW]),
                .reg_data  (r_regs[rd_addr[p*AW +: AW]]),
                .wr_accept (w_wr_accept),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .rd_data   (rd_data[p*XLEN +: XLEN])
            );
        end
    endgenerate

    assign wr_done  = r_wr_done;
    assign clr_done = r_clr_done;
    assign busy     = (r_state == RF_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_rvc_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvc_regfile_mp
//  Description : Self-checking bench for rvc_regfile_mp (NREG=32, 2 ports)
//                plus a NREG=20 instance for out-of-range indices.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rvc_regfile_mp;

`ifdef RVC_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_done;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        clr_req = 1'b0;
    logic        busy;
    logic        clr_done;

    logic        wr_en20 = 1'b0;
    logic [4:0]  wr_addr20 = '0;
    logic [31:0] wr_data20 = '0;
    logic        wr_done20;
    logic [4:0]  rd_addr20 = '0;
    logic [31:0] rd_data20;
    logic        clr_req20 = 1'b0;
    logic        busy20;
    logic        clr_done20;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          port;   // -1 selects wr_done
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_regs [32];

    always #5 clk = ~clk;

    rvc_regfile_mp #(.XLEN(32), .NREG(32), .NRP(2)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done)
    );

    rvc_regfile_mp #(.XLEN(32), .NREG(20), .NRP(1)) u_dut20 (
        .clk(clk), .rst(rst), .wr_en(wr_en20), .wr_addr(wr_addr20), .wr_data(wr_data20),
        .wr_done(wr_done20), .rd_addr(rd_addr20), .rd_data(rd_data20), .clr_req(clr_req20),
        .busy(busy20), .clr_done(clr_done20)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, queue expected results from the model, then compare
    task automatic drive(input bit wen, input int waddr, input logic [31:0] wdata,
                         input bit clr, input int a0, input int a1, input bit in_clear);
        bit          acc;
        int          addrs [2];
        logic [31:0] e;
        exp_t        s;
        acc = !in_clear && wen && !clr && (waddr != 0) && (waddr < 32);
        addrs[0] = a0;
        addrs[1] = a1;
        for (int p = 0; p < 2; p++) begin
            if (addrs[p] == 0 || addrs[p] >= 32) e = 32'h0;
            else if (BYP && acc && addrs[p] == waddr) e = wdata;
            else e = m_regs[addrs[p]];
            s.tag  = $sformatf("rd%0d_x%0d", p, addrs[p]);
            s.port = p;
            s.exp  = e;
            sbq.push_back(s);
        end
        s.tag  = $sformatf("wr_done_x%0d", waddr);
        s.port = -1;
        s.exp  = {31'b0, acc};
        sbq.push_back(s);

        wr_en   = wen;
        wr_addr = 5'(waddr);
        wr_data = wdata;
        clr_req = clr;
        rd_addr = {5'(a1), 5'(a0)};
        step();
        wr_en   = 1'b0;
        clr_req = 1'b0;

        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            if (s.port < 0) check(s.tag, {31'b0, wr_done}, s.exp);
            else            check(s.tag, rd_data[s.port*32 +: 32], s.exp);
        end
        if (acc) m_regs[waddr] = wdata;
    endtask

    // Count busy cycles and clr_done pulses until the clear finishes
    task automatic wait_clear(input int start_busy, output int nb, output int nd);
        bool_loop: begin
            nb = start_busy;
            nd = 0;
            for (int i = 0; i < 200; i++) begin
                step();
                if (busy) nb++;
                if (clr_done) nd++;
                if (!busy) disable bool_loop;
            end
            check("clr_timeout", 32'd1, 32'd0);
        end
        repeat (3) begin
            step();
            if (clr_done) nd++;
        end
    endtask

    initial begin
        int nb;
        int nd;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        // 1: reset, initial clear
        rst = 1'b1;
        step();
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_wr_done", {31'b0, wr_done}, 32'd0);
        check("rst_clr_done", {31'b0, clr_done}, 32'd0);
        check("rst_rd_data0", rd_data[31:0], 32'h0);
        check("rst_rd_data1", rd_data[63:32], 32'h0);
        rst = 1'b0;
        wait_clear(1, nb, nd);
        check("init_busy_cycles", 32'(nb), 32'd31);
        check("init_clr_done_pulses", 32'(nd), 32'd1);
        for (int i = 1; i < 32; i++) drive(0, 0, 32'h0, 0, i, 32 - i, 0);

        // 2: basic write and read
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 5, 0, 0);
        check("wr_done_one_cycle", {31'b0, wr_done}, 32'd0);

        // 3: x0 write is discarded
        drive(1, 0, 32'h12345678, 0, 0, 5, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 0);

        // 4: same-cycle write and read
        drive(1, 7, 32'h1, 0, 0, 0, 0);
        drive(1, 7, 32'hA5A5A5A5, 0, 7, 7, 0);
        drive(0, 0, 32'h0, 0, 7, 5, 0);

        // 5: fill, clear with colliding write, write during clear
        for (int i = 1; i < 32; i++) drive(1, i, 32'(i), 0, i, i - 1, 0);
        drive(1, 3, 32'h99, 1, 3, 0, 0);
        check("clr_busy_start", {31'b0, busy}, 32'd1);
        drive(1, 4, 32'h55, 0, 0, 0, 1);
        wait_clear(1, nb, nd);
        check("clr_busy_cycles", 32'(nb), 32'd30);
        check("clr_done_pulses", 32'(nd), 32'd1);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 1; i < 32; i++) drive(0, 0, 32'h0, 0, i, 32 - i, 0);

        // 6: reset mid-clear restarts the clear
        drive(1, 2, 32'h22, 0, 0, 0, 0);
        drive(1, 20, 32'h77, 0, 2, 0, 0);
        drive(0, 0, 32'h0, 1, 20, 2, 0);
        repeat (9) step();
        check("mid_clr_busy", {31'b0, busy}, 32'd1);
        check("mid_clr_no_done", {31'b0, clr_done}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("restart_busy", {31'b0, busy}, 32'd1);
        wait_clear(1, nb, nd);
        check("restart_busy_cycles", 32'(nb), 32'd31);
        check("restart_clr_done_pulses", 32'(nd), 32'd1);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        drive(0, 0, 32'h0, 0, 2, 20, 0);

        // NREG=20 instance: out-of-range index handling
        check("n20_idle", {31'b0, busy20}, 32'd0);
        wr_en20 = 1'b1; wr_addr20 = 5'd25; wr_data20 = 32'hCAFE0001; rd_addr20 = 5'd25;
        step();
        wr_en20 = 1'b0;
        check("n20_wr25_done", {31'b0, wr_done20}, 32'd0);
        check("n20_rd25", rd_data20, 32'h0);
        wr_en20 = 1'b1; wr_addr20 = 5'd19; wr_data20 = 32'h000000AB; rd_addr20 = 5'd25;
        step();
        wr_en20 = 1'b0;
        check("n20_wr19_done", {31'b0, wr_done20}, 32'd1);
        check("n20_rd25_again", rd_data20, 32'h0);
        rd_addr20 = 5'd19;
        step();
        check("n20_rd19", rd_data20, 32'h000000AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
